// File: rtl/elevator_pkg.sv
// elevator_pkg: shared state encoding, direction constants and floor helper for the SCAN elevator.
package elevator_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_MOVING, ST_DOOR_OPEN} state_e;
  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DOWN = 1'b0;
  // Saturating one-floor step; callers cast the result back to their FLOOR_W.
  function automatic int unsigned step_floor(int unsigned f, logic up, int unsigned top);
    return up ? (f < top ? f + 1 : f) : (f > 0 ? f - 1 : f);
  endfunction
endpackage

// File: rtl/elevator_req_scan.sv
// elevator_req_scan: classifies pending requests as here / ahead / behind relative to a floor and direction.
module elevator_req_scan
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W = $clog2(NUM_FLOORS)
) (
  input  logic [NUM_FLOORS-1:0] pending_i,
  input  logic [FLOOR_W-1:0]    floor_i,
  input  logic                  dir_up_i,
  output logic                  here_o,
  output logic                  ahead_o,
  output logic                  behind_o
);
  logic [NUM_FLOORS-1:0] above, below, at;
  logic up_any, dn_any;
  always_comb
    for (int i = 0; i < NUM_FLOORS; i++) begin
      above[i] = i > int'(floor_i);
      below[i] = i < int'(floor_i);
      at[i]    = i == int'(floor_i);
    end
  assign up_any   = |(pending_i & above);
  assign dn_any   = |(pending_i & below);
  assign here_o   = |(pending_i & at);
  assign ahead_o  = (dir_up_i == DIR_UP) ? up_any : dn_any;
  assign behind_o = (dir_up_i == DIR_UP) ? dn_any : up_any;
endmodule

// File: rtl/elevator_scan_ctrl.sv
// elevator_scan_ctrl: parametrised SCAN-order elevator controller with timed travel and timed door.
module elevator_scan_ctrl
  import elevator_pkg::*;
#(
  parameter int NUM_FLOORS = 5,
  parameter int FLOOR_W = $clog2(NUM_FLOORS),
  parameter int TRAVEL_CYCLES = 4,
  parameter int DOOR_CYCLES = 3
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_FLOORS-1:0] req_i,
  output logic [FLOOR_W-1:0]    current_floor,
  output logic                  door_open,
  output logic                  moving,
  output logic                  dir_up,
  output logic [NUM_FLOORS-1:0] pending_o
);
  localparam int TMAX = TRAVEL_CYCLES > DOOR_CYCLES ? TRAVEL_CYCLES : DOOR_CYCLES;
  localparam int TW = $clog2(TMAX + 1);
  localparam logic [TW-1:0] T_TRAVEL = TW'(TRAVEL_CYCLES - 1);
  localparam logic [TW-1:0] T_DOOR = TW'(DOOR_CYCLES - 1);

  state_e                state_q, state_d;
  logic [TW-1:0]         timer_q, timer_d;
  logic [FLOOR_W-1:0]    floor_q, floor_d;
  logic                  dir_q, dir_d;
  logic [NUM_FLOORS-1:0] pend_q, pend_d, clr;
  logic                  arrive, decide, hold, here, ahead, behind;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= ST_IDLE;
      timer_q <= '0;
      floor_q <= '0;
      dir_q   <= DIR_UP;
      pend_q  <= '0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      floor_q <= floor_d;
      dir_q   <= dir_d;
      pend_q  <= pend_d;
    end

  // On an arrival edge the SCAN decision is taken at the floor being reached.
  assign arrive  = state_q == ST_MOVING && timer_q == '0;
  assign decide  = state_q == ST_IDLE || arrive;
  assign floor_d = arrive ? FLOOR_W'(step_floor(32'(floor_q), dir_q, NUM_FLOORS - 1)) : floor_q;
  assign hold    = |(req_i & (NUM_FLOORS'(1) << floor_q));

  elevator_req_scan #(.NUM_FLOORS(NUM_FLOORS), .FLOOR_W(FLOOR_W)) u_scan (
    .pending_i(pend_q),
    .floor_i  (floor_d),
    .dir_up_i (dir_q),
    .here_o   (here),
    .ahead_o  (ahead),
    .behind_o (behind)
  );

  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    dir_d   = dir_q;
    if (decide) begin
      if (here) begin
        state_d = ST_DOOR_OPEN;
        timer_d = T_DOOR;
      end else if (ahead || behind) begin
        state_d = ST_MOVING;
        timer_d = T_TRAVEL;
        dir_d   = ahead ? dir_q : ~dir_q;
      end else
        state_d = ST_IDLE;
    end else if (state_q == ST_DOOR_OPEN) begin
      state_d = (!hold && timer_q == '0) ? ST_IDLE : ST_DOOR_OPEN;
      timer_d = hold ? T_DOOR : (timer_q == '0 ? timer_q : timer_q - 1'b1);
    end else
      timer_d = timer_q - 1'b1;
    clr    = (state_q == ST_DOOR_OPEN || state_d == ST_DOOR_OPEN) ? NUM_FLOORS'(1) << floor_d : '0;
    pend_d = (pend_q | req_i) & ~clr;
  end

  always_comb begin
    door_open     = state_q == ST_DOOR_OPEN;
    moving        = state_q == ST_MOVING;
    dir_up        = dir_q;
    current_floor = floor_q;
    pending_o     = pend_q;
  end
endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// tb_elevator_scan_ctrl: scoreboard bench for the SCAN elevator at 5 floors, 4-cycle travel, 3-cycle door.
module tb_elevator_scan_ctrl;
  typedef struct packed {
    logic [2:0] fl;
    logic       door;
    logic       mov;
    logic       dir;
    logic [4:0] pend;
  } snap_t;

  logic       clk = 0;
  logic       rst_n = 0;
  logic [4:0] req_i = '0;
  logic [2:0] current_floor;
  logic       door_open, moving, dir_up;
  logic [4:0] pending_o;
  snap_t      obs, e;
  snap_t      sb[$];
  int         tests = 0;
  int         fails = 0;

  elevator_scan_ctrl #(.NUM_FLOORS(5), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_i        (req_i),
    .current_floor(current_floor),
    .door_open    (door_open),
    .moving       (moving),
    .dir_up       (dir_up),
    .pending_o    (pending_o)
  );

  always #5 clk = ~clk;
  assign obs = {current_floor, door_open, moving, dir_up, pending_o};

  function automatic snap_t mk(int f, bit d, bit m, bit u, int p);
    return '{3'(f), d, m, u, 5'(p)};
  endfunction

  function automatic snap_t pop();
    pop = 'x;
    if (sb.size() != 0) pop = sb.pop_front();
  endfunction

  function automatic string fmt(snap_t s);
    return $sformatf("fl=%0d door=%0b mov=%0b dir=%0b pend=%b", s.fl, s.door, s.mov, s.dir, s.pend);
  endfunction

  task automatic cycle(input logic [4:0] r);
    req_i = r;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    sb.delete();
    req_i = '0;
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    rst_n = 0;
    req_i = '1;
    repeat (3) @(negedge clk);
    sb.push_back(mk(0, 0, 0, 1, 0));
    e = pop(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_hold: got %s want %s", fmt(obs), fmt(e)); end
    req_i = '0;
    rst_n = 1;
    sb.push_back(mk(0, 0, 0, 1, 8));
    cycle(5'b01000);
    e = pop(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_latch: got %s want %s", fmt(obs), fmt(e)); end
    #2 rst_n = 0;
    sb.push_back(mk(0, 0, 0, 1, 0));
    #1;
    e = pop(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_async: got %s want %s", fmt(obs), fmt(e)); end
    @(negedge clk);
    sb.push_back(mk(0, 0, 0, 1, 0));
    cycle(5'b01000);
    e = pop(); tests++;
    if (obs !== e) begin fails++; $display("FAIL reset_req_held: got %s want %s", fmt(obs), fmt(e)); end
  endtask

  task automatic test_same_floor();
    reset_dut();
    sb.push_back(mk(0, 0, 0, 1, 1));
    repeat (3) sb.push_back(mk(0, 1, 0, 1, 0));
    repeat (2) sb.push_back(mk(0, 0, 0, 1, 0));
    for (int i = 0; i < 6; i++) begin
      cycle(i == 0 ? 5'b00001 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL same_floor[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_travel();
    reset_dut();
    sb.push_back(mk(0, 0, 0, 1, 8));
    for (int i = 0; i < 12; i++) sb.push_back(mk(i / 4, 0, 1, 1, 8));
    repeat (3) sb.push_back(mk(3, 1, 0, 1, 0));
    sb.push_back(mk(3, 0, 0, 1, 0));
    for (int i = 0; i < 17; i++) begin
      cycle(i == 0 ? 5'b01000 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL travel[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_scan_order();
    reset_dut();
    for (int i = 0; i < 37; i++)
      if (i == 0) sb.push_back(mk(0, 0, 0, 1, 16));
      else if (i < 17) sb.push_back(mk((i - 1) / 4, 0, 1, 1, i < 10 ? 16 : 18));
      else if (i < 20) sb.push_back(mk(4, 1, 0, 1, 2));
      else if (i == 20) sb.push_back(mk(4, 0, 0, 1, 2));
      else if (i < 33) sb.push_back(mk(4 - (i - 21) / 4, 0, 1, 0, 2));
      else if (i < 36) sb.push_back(mk(1, 1, 0, 0, 0));
      else sb.push_back(mk(1, 0, 0, 0, 0));
    for (int i = 0; i < 37; i++) begin
      cycle(i == 0 ? 5'b10000 : (i == 10 ? 5'b00010 : 5'b0));
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL scan[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_door_hold();
    reset_dut();
    sb.push_back(mk(0, 0, 0, 1, 4));
    for (int i = 1; i < 9; i++) sb.push_back(mk((i - 1) / 4, 0, 1, 1, 4));
    repeat (5) sb.push_back(mk(2, 1, 0, 1, 0));
    sb.push_back(mk(2, 0, 0, 1, 0));
    for (int i = 0; i < 15; i++) begin
      cycle((i == 0 || i == 11) ? 5'b00100 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL door_hold[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back();
    reset_dut();
    for (int i = 0; i < 29; i++)
      if (i == 0) sb.push_back(mk(0, 0, 0, 1, 21));
      else if (i < 4) sb.push_back(mk(0, 1, 0, 1, 20));
      else if (i == 4) sb.push_back(mk(0, 0, 0, 1, 20));
      else if (i < 13) sb.push_back(mk((i - 5) / 4, 0, 1, 1, 20));
      else if (i < 16) sb.push_back(mk(2, 1, 0, 1, 16));
      else if (i == 16) sb.push_back(mk(2, 0, 0, 1, 16));
      else if (i < 25) sb.push_back(mk(2 + (i - 17) / 4, 0, 1, 1, 16));
      else if (i < 28) sb.push_back(mk(4, 1, 0, 1, 0));
      else sb.push_back(mk(4, 0, 0, 1, 0));
    for (int i = 0; i < 29; i++) begin
      cycle(i == 0 ? 5'b10101 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL back_to_back[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  task automatic test_reset_mid_move();
    reset_dut();
    sb.push_back(mk(0, 0, 0, 1, 4));
    for (int i = 1; i < 7; i++) sb.push_back(mk((i - 1) / 4, 0, 1, 1, 4));
    for (int i = 0; i < 7; i++) begin
      cycle(i == 0 ? 5'b00100 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL mid_move_pre[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
    #2 rst_n = 0;
    sb.push_back(mk(0, 0, 0, 1, 0));
    #1;
    e = pop(); tests++;
    if (obs !== e) begin fails++; $display("FAIL mid_move_reset: got %s want %s", fmt(obs), fmt(e)); end
    @(negedge clk);
    rst_n = 1;
    sb.push_back(mk(0, 0, 0, 1, 0));
    sb.push_back(mk(0, 0, 0, 1, 4));
    for (int i = 2; i < 10; i++) sb.push_back(mk((i - 2) / 4, 0, 1, 1, 4));
    repeat (2) sb.push_back(mk(2, 1, 0, 1, 0));
    for (int i = 0; i < 12; i++) begin
      cycle(i == 1 ? 5'b00100 : 5'b0);
      e = pop(); tests++;
      if (obs !== e) begin fails++; $display("FAIL mid_move_post[%0d]: got %s want %s", i, fmt(obs), fmt(e)); end
    end
  endtask

  initial begin
    test_reset();
    test_same_floor();
    test_travel();
    test_scan_order();
    test_door_hold();
    test_back_to_back();
    test_reset_mid_move();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/elevator_scan_ctrl.md
Name: elevator_scan_ctrl

Overview:
- Parametrised multi-floor elevator controller; successor to the fixed 5-floor, unclocked-door controller.
- Latches floor requests and serves them in SCAN (collective) order. Models floor-to-floor travel time and a timed door.
- Exposes position, direction, door and pending-request state for display and testbench logic.
- Sits between the button/request front end and the car status display.

Parameters:
- NUM_FLOORS, 5, number of floors (>=2); floors numbered 0..NUM_FLOORS-1.
- FLOOR_W, $clog2(NUM_FLOORS), width of the floor index.
- TRAVEL_CYCLES, 4, clock cycles to move one floor (>=1).
- DOOR_CYCLES, 3, clock cycles the door stays open (>=1).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- req_i  input  NUM_FLOORS  floor request bits; any-cycle pulse or level, OR-latched.
- current_floor  output  FLOOR_W  floor the car is at or last departed.
- door_open  output  1  1 = door open.
- moving  output  1  1 = car travelling between floors.
- dir_up  output  1  current/preferred direction: 1 = up, 0 = down.
- pending_o  output  NUM_FLOORS  latched, not-yet-served requests.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous and active-low.
- Reset (async assert, sync release) forces:
  - state = IDLE; all timers = 0.
  - current_floor = 0, door_open = 0, moving = 0, dir_up = 1, pending_o = 0.
  - Reset mid-travel or mid-door also forces these values; position is lost and the car restarts at floor 0.
- Request latch, every edge: pending <= (pending | req_i) & ~clr.
  - clr = one-hot(current_floor) on the DOOR_OPEN entry edge and for every cycle in DOOR_OPEN. All other cycles clr = 0.
  - A request is visible on pending_o one cycle after req_i.
  - req_i for the departed floor during MOVING is latched and served later.
- Ahead/behind terms:
  - ahead = any pending bit above current_floor if dir_up, else any pending bit below it.
  - behind = the same test in the opposite direction.
- SCAN decision, applied in IDLE and on every floor arrival, in priority order:
  - (1) pending[current_floor] set: go to DOOR_OPEN.
  - (2) ahead: go to / stay in MOVING.
  - (3) behind: toggle dir_up, then go to MOVING.
  - (4) none of the above: go to IDLE.
- State IDLE:
  - moving = 0, door_open = 0.
  - Applies the decision each edge. Therefore at least one IDLE cycle always separates door close from departure.
- State MOVING:
  - moving = 1; timer loaded with TRAVEL_CYCLES-1 on entry and decremented each edge.
  - On the edge where timer == 0: current_floor moves +1 (dir_up) or -1. Then the decision applies; if the result is MOVING, the timer reloads.
  - A move spends exactly TRAVEL_CYCLES cycles per floor.
- State DOOR_OPEN:
  - door_open = 1; timer loaded with DOOR_CYCLES-1 on entry.
  - req_i[current_floor] = 1 while open reloads the timer (door hold) and is not latched.
  - On timer expiry, go to IDLE; door_open = 0 on that edge.
- Boundaries:
  - Never decrements below 0 or increments above NUM_FLOORS-1.
  - At floor 0 with dir_up = 0, or at the top floor with dir_up = 1, "ahead" is empty, so direction reverses only if "behind" is set.
- Simultaneous requests on several floors are all latched in the same cycle.
- req_i bits are never lost except the current floor's bit while the door is open.

Decomposition:
- Shared package elevator_pkg holds:
  - state enum (ST_IDLE, ST_MOVING, ST_DOOR_OPEN);
  - direction constants DIR_UP = 1'b1, DIR_DOWN = 1'b0;
  - floor index helper function using FLOOR_W.
- One natural sub-module: elevator_req_scan, combinational.
  - Inputs: pending, current_floor, dir_up.
  - Outputs: here, ahead, behind.
  - Parametrised on NUM_FLOORS, using masked OR-reduction.

Test Plan (NUM_FLOORS=5, TRAVEL_CYCLES=4, DOOR_CYCLES=3):
- Reset: hold rst_n=0 with req_i=5'b11111 -> current_floor=0, door_open=0, moving=0, dir_up=1, pending_o=0. Assert rst_n asynchronously mid-cycle -> outputs clear before the next edge.
- Same-floor call: idle at 0, pulse req_i=5'b00001 -> pending_o[0]=1 next cycle, then door_open=1 for exactly 3 cycles, pending_o[0]=0, moving never 1.
- Travel: idle at 0, pulse req_i[3] -> moving=1 for 12 cycles, current_floor steps 1,2,3 every 4 cycles, then door_open=1 for 3 cycles, pending_o=0.
- SCAN ordering: from 0 request floor 4; while passing floor 2 pulse req_i[1] -> car continues to 4 and opens. Then dir_up=0, travel to 1 and open. Floor 1 is not served first.
- Door hold: door open at floor 2, pulse req_i[2] on the 2nd open cycle -> door_open stays 1 for 3 more cycles, pending_o[2] stays 0.
- Reset mid-move: while moving 1->2, drop rst_n -> current_floor=0, moving=0, pending_o=0. A subsequent req_i[2] is served normally.
